// File: rtl/m_axi_reg_master.sv
// Single-outstanding AXI initiator: turns one command into a single-beat write
// (AW+W then B) or read (AR then R) against the register bank and returns one response.
module m_axi_reg_master #(
  parameter int unsigned BRAM_QUANTITY = 8,
  parameter logic [3:0]  ID_INIT       = 4'h0
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_write_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_bresp_o,
  output logic        rsp_err_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [3:0]  rstrb_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t     state;
  logic [3:0] txn_id;
  logic       bus_issued;
  logic       aw_fin;
  logic       w_fin;

  // Single-beat reads carry no strobe and need no last-beat check.
  logic unused_rd_sideband;
  assign unused_rd_sideband = ^{rstrb_i, rlast_i};

  // A channel is finished once its valid has dropped or is handshaking this edge.
  assign aw_fin = ~awvalid_o | awready_i;
  assign w_fin  = ~wvalid_o | wready_i;

  always_ff @(posedge clk) begin
    if (areset) begin
      state       <= IDLE;
      txn_id      <= ID_INIT;
      bus_issued  <= 1'b0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_write_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_bresp_o <= 2'b00;
      rsp_err_o   <= 1'b0;
      awid_o      <= '0;
      awaddr_o    <= '0;
      awvalid_o   <= 1'b0;
      wid_o       <= '0;
      wdata_o     <= '0;
      wstrb_o     <= '0;
      wlast_o     <= 1'b0;
      wvalid_o    <= 1'b0;
      arid_o      <= '0;
      araddr_o    <= '0;
      arvalid_o   <= 1'b0;
      rready_o    <= 1'b0;
      bready_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            rsp_write_o <= cmd_write_i;
            rsp_rdata_o <= '0;
            rsp_bresp_o <= 2'b00;
            rsp_err_o   <= 1'b0;
            if (cmd_addr_i >= BRAM_QUANTITY) begin
              // Out-of-range: answer locally, the bus and the ID stay untouched.
              bus_issued  <= 1'b0;
              rsp_err_o   <= 1'b1;
              rsp_bresp_o <= 2'b10;
              rsp_valid_o <= 1'b1;
              state       <= RSP;
            end else if (cmd_write_i) begin
              bus_issued <= 1'b1;
              awid_o     <= txn_id;
              awaddr_o   <= cmd_addr_i;
              awvalid_o  <= 1'b1;
              wid_o      <= txn_id;
              wdata_o    <= cmd_wdata_i;
              wstrb_o    <= cmd_wstrb_i;
              wlast_o    <= 1'b1;
              wvalid_o   <= 1'b1;
              state      <= WR_ADDR_DATA;
            end else begin
              bus_issued <= 1'b1;
              arid_o     <= txn_id;
              araddr_o   <= cmd_addr_i;
              arvalid_o  <= 1'b1;
              state      <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (awready_i) awvalid_o <= 1'b0;
          if (wready_i)  wvalid_o  <= 1'b0;
          if (aw_fin && w_fin) begin
            bready_o <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid_i) begin
            bready_o    <= 1'b0;
            rsp_bresp_o <= bresp_i;
            rsp_err_o   <= (bid_i != txn_id);
            rsp_valid_o <= 1'b1;
            state       <= RSP;
          end
        end
        RD_ADDR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid_i) begin
            rready_o    <= 1'b0;
            rsp_rdata_o <= rdata_i;
            rsp_err_o   <= (rid_i != txn_id);
            rsp_valid_o <= 1'b1;
            state       <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            if (bus_issued) txn_id <= txn_id + 4'd1;
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/m_axi_reg_master.md
Name: m_axi_reg_master

Overview:
- Single-outstanding AXI initiator that drives the register-bank slave (`s_axi_reg`) from a simple command/response interface.
- Converts one command into either a single-beat write (AW+W, then B) or a single-beat read (AR, then R), then returns one response.
- Sits between control logic (counter sequencer, test driver) and the AXI slave port of the register bank.

Parameters:
- BRAM_QUANTITY, 8: number of 32-bit words in the target bank; valid word addresses are 0..BRAM_QUANTITY-1.
- ID_INIT, 4'h0: transaction ID used for the first transaction after reset.

Ports:
- clk  in  1  clock; all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  32  word address (bank index)
- cmd_wdata_i  in  32  write data
- cmd_wstrb_i  in  4  byte strobes for write
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_write_o  out  1  echo of the command type
- rsp_rdata_o  out  32  read data (0 for writes)
- rsp_bresp_o  out  2  bresp for writes; 2'b00 for reads
- rsp_err_o  out  1  address out of range, or ID mismatch on B/R
- awid_o  out  4,  awaddr_o  out  32,  awvalid_o  out  1,  awready_i  in  1
- wid_o  out  4,  wdata_o  out  32,  wstrb_o  out  4,  wlast_o  out  1,  wvalid_o  out  1,  wready_i  in  1
- arid_o  out  4,  araddr_o  out  32,  arvalid_o  out  1,  arready_i  in  1
- rid_i  in  4,  rdata_i  in  32,  rstrb_i  in  4 (ignored),  rlast_i  in  1,  rvalid_i  in  1,  rready_o  out  1
- bid_i  in  4,  bresp_i  in  2,  bvalid_i  in  1,  bready_o  out  1

Behaviour:
- Reset (areset=1 at an edge):
  - All valid/ready outputs = 0, except cmd_ready_o = 1.
  - All address, data, ID and strobe outputs = 0; rsp_* = 0.
  - txn_id = ID_INIT; state = IDLE.
  - Reset mid-transaction abandons it immediately; no response is produced.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- cmd_ready_o is 1 only in IDLE.
- IDLE, on cmd_valid_i at edge N:
  - Latch addr, wdata, wstrb, write.
  - If cmd_addr_i >= BRAM_QUANTITY: go to RSP with rsp_err_o = 1 and rsp_bresp_o = 2'b10. No bus activity; txn_id unchanged.
  - Else write: awvalid_o = wvalid_o = 1 from cycle N+1; awid_o = wid_o = txn_id; wlast_o = 1. Enter WR_ADDR_DATA.
  - Else read: arvalid_o = 1, arid_o = txn_id. Enter RD_ADDR.
- WR_ADDR_DATA:
  - awvalid_o and wvalid_o each drop independently after their own handshake.
  - Payloads stay stable while valid is high; valid is never withdrawn before its handshake.
  - When both handshakes are complete (same or different cycles), enter WR_RESP with bready_o = 1.
- WR_RESP, on bvalid_i:
  - Capture bresp_i.
  - rsp_err_o = (bid_i != txn_id).
  - bready_o -> 0; enter RSP.
- RD_ADDR: on arready_i, arvalid_o -> 0; enter RD_DATA with rready_o = 1.
- RD_DATA, on rvalid_i:
  - Capture rdata_i; rsp_err_o = (rid_i != txn_id).
  - rlast_i is not checked (single beat).
  - rready_o -> 0; enter RSP.
- RSP:
  - rsp_valid_o = 1; fields held stable until rsp_ready_i.
  - On handshake: rsp_valid_o -> 0, return to IDLE, txn_id += 1 (4-bit wrap 4'hF -> 4'h0) if a bus transaction was issued.
- Latency:
  - With all slave readies/valids asserted immediately, a write gives rsp_valid_o at N+3.
  - A read gives rsp_valid_o at N+3.
  - Out-of-range commands give rsp_valid_o at N+1.
- No combinational path from any AXI input to any AXI output; all outputs are registered.

Test Plan:
- Write addr 3, data 0xDEADBEEF, strb 4'hF, slave always ready, bresp 00, bid echoes -> AW/W both valid at N+1 with awid = 0; rsp_valid at N+3, rsp_bresp = 00, rsp_err = 0.
- Read addr 3 after the above (slave returns 0xDEADBEEF, rid = 1) -> arid_o = 1; rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr; bready only after both handshakes.
- cmd_addr = 8 with BRAM_QUANTITY = 8 -> no AW/AR activity; rsp_err = 1, rsp_bresp = 10 at N+1; next transaction still uses the same ID.
- Slave returns bid != awid -> rsp_err = 1; 16 back-to-back valid writes -> IDs 0..F, then wrap to 0.
- areset asserted while in RD_DATA with rsp_ready_i held low -> next cycle all valids 0, cmd_ready = 1, no rsp_valid.
